// File: rtl/commit_trace_if.sv
// Commit-side and drain-side signals of the commit trace recorder.
// The pipeline/consumer is the master; the recorder is the slave.
interface commit_trace_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 32
);
  logic              commit_valid;
  logic [ADDR_W-1:0] commit_pc;
  logic              commit_regwrite;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_wdata;
  logic              commit_memread;
  logic              commit_memwrite;
  logic [ADDR_W-1:0] commit_maddr;
  logic [DATA_W-1:0] commit_mdata;
  logic              commit_halt;

  logic              rd_ready;
  logic              rd_valid;
  logic [1:0]        rd_kind;
  logic [CNT_W-1:0]  rd_inum;
  logic [ADDR_W-1:0] rd_pc;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_value;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_load;

  modport master (
    output commit_valid, commit_pc, commit_regwrite, commit_rd, commit_wdata,
           commit_memread, commit_memwrite, commit_maddr, commit_mdata, commit_halt,
           rd_ready,
    input  rd_valid, rd_kind, rd_inum, rd_pc, rd_reg, rd_value, rd_addr, rd_load
  );

  modport slave (
    input  commit_valid, commit_pc, commit_regwrite, commit_rd, commit_wdata,
           commit_memread, commit_memwrite, commit_maddr, commit_mdata, commit_halt,
           rd_ready,
    output rd_valid, rd_kind, rd_inum, rd_pc, rd_reg, rd_value, rd_addr, rd_load
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// On-chip commit trace: one record per retired instruction into a circular
// buffer, drained through a first-word-fall-through valid/ready port.
module commit_trace_buffer #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int REG_W        = 4,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 32,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  commit_trace_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           inst_count,
  output logic [CNT_W-1:0]           cycle_count,
  output logic                       halted,
  output logic                       frozen,
  output logic                       overflow,
  output logic [CNT_W-1:0]           dropped
);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {RUN, FROZEN, HALTED} state_t;
  typedef enum logic [1:0] {KIND_OTHER, KIND_REG, KIND_STORE, KIND_HALT} kind_t;

  typedef struct packed {
    kind_t             kind;
    logic [CNT_W-1:0]  inum;
    logic [ADDR_W-1:0] pc;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] value;
    logic [ADDR_W-1:0] addr;
    logic              load;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic accept, pop, full, do_write, overwrite, refuse, grow;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    new_entry      = '0;
    new_entry.inum = inst_count;
    new_entry.pc   = bus.commit_pc;
    if (bus.commit_halt) begin
      new_entry.kind = KIND_HALT;
    end else if (bus.commit_regwrite) begin
      new_entry.kind  = KIND_REG;
      new_entry.rg    = bus.commit_rd;
      new_entry.value = bus.commit_wdata;
      new_entry.addr  = bus.commit_maddr;
      new_entry.load  = bus.commit_memread;
    end else if (bus.commit_memwrite) begin
      new_entry.kind  = KIND_STORE;
      new_entry.value = bus.commit_mdata;
      new_entry.addr  = bus.commit_maddr;
    end
  end

  // A full buffer either sheds its oldest record or refuses the new one,
  // unless a pop frees the slot in the same cycle.
  always_comb begin
    accept    = bus.commit_valid && (state != HALTED);
    pop       = bus.rd_ready && (level != '0);
    full      = (level == FULL_LVL);
    overwrite = accept && full && !pop && (STOP_ON_FULL == 0);
    refuse    = accept && full && !pop && (STOP_ON_FULL != 0);
    do_write  = accept && !refuse;
    grow      = do_write && !overwrite;
  end

  // NOTE: the record storage is deliberately not reset; emptiness is tracked
  // by level and the pointers, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_write) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state       <= RUN;
      halted      <= 1'b0;
      frozen      <= 1'b0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      dropped     <= '0;
    end else begin
      if (do_write)         wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop || overwrite) rd_ptr <= rd_ptr + PTR_W'(1);

      if (grow && !pop)      level <= level + LVL_W'(1);
      else if (!grow && pop) level <= level - LVL_W'(1);

      if (accept)             inst_count <= inst_count + CNT_W'(1);
      if (overwrite)          overflow   <= 1'b1;
      if (overwrite || refuse) dropped   <= dropped + CNT_W'(1);

      if (state != HALTED && cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end

      case (state)
        RUN: begin
          if (accept && bus.commit_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (refuse) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end
        end
        FROZEN: begin
          if (accept && bus.commit_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
            frozen <= 1'b0;
          end else if (pop) begin
            state  <= RUN;
            frozen <= 1'b0;
          end
        end
        HALTED: ;
        default: begin
          state  <= RUN;
          halted <= 1'b0;
          frozen <= 1'b0;
        end
      endcase
    end
  end

  // Head fields read as zero while empty so no unwritten storage leaks out.
  assign head         = (level != '0) ? mem[rd_ptr] : '0;
  assign bus.rd_valid = (level != '0);
  assign bus.rd_kind  = head.kind;
  assign bus.rd_inum  = head.inum;
  assign bus.rd_pc    = head.pc;
  assign bus.rd_reg   = head.rg;
  assign bus.rd_value = head.value;
  assign bus.rd_addr  = head.addr;
  assign bus.rd_load  = head.load;
endmodule
